// File: rtl/exhaustive_vector_checker_if.sv
// exhaustive_vector_checker_if: start/vector/response/result bundle between the checker and its environment
interface exhaustive_vector_checker_if;
    logic       start;
    logic       a;
    logic       b;
    logic       c;
    logic       x;
    logic       y;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_vec;
    logic [1:0] first_fail_xy;
    logic [7:0] cap_x;
    logic [7:0] cap_y;
    modport master (
        input  start, x, y,
        output a, b, c, busy, done, pass, err_count, first_fail_vec, first_fail_xy, cap_x, cap_y
    );
    modport slave (
        output start, x, y,
        input  a, b, c, busy, done, pass, err_count, first_fail_vec, first_fail_xy, cap_x, cap_y
    );
endinterface

// File: rtl/exhaustive_vector_checker.sv
// exhaustive_vector_checker: sweeps {a,b,c} 000..111, samples {x,y} after HOLD_CYCLES and grades against truth tables
module exhaustive_vector_checker #(
    parameter int         HOLD_CYCLES = 4,
    parameter logic [7:0] EXP_X       = 8'b1110_1000,
    parameter logic [7:0] EXP_Y       = 8'b1001_0110
) (
    input logic clk,
    input logic rst_n,
    exhaustive_vector_checker_if.master bus
);
    localparam int HW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state;
    logic [2:0] vec;
    logic [HW-1:0] hold_cnt;
    logic mismatch;
    assign {bus.a, bus.b, bus.c} = vec;
    assign mismatch = (bus.x != EXP_X[vec]) | (bus.y != EXP_Y[vec]);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= IDLE;
            vec                <= '0;
            hold_cnt           <= '0;
            bus.busy           <= 1'b0;
            bus.done           <= 1'b0;
            bus.pass           <= 1'b0;
            bus.err_count      <= '0;
            bus.first_fail_vec <= '0;
            bus.first_fail_xy  <= '0;
            bus.cap_x          <= '0;
            bus.cap_y          <= '0;
        end else if (state != RUN) begin
            if (bus.start) begin
                state              <= RUN;
                vec                <= '0;
                hold_cnt           <= '0;
                bus.busy           <= 1'b1;
                bus.done           <= 1'b0;
                bus.pass           <= 1'b0;
                bus.err_count      <= '0;
                bus.first_fail_vec <= '0;
                bus.first_fail_xy  <= '0;
                bus.cap_x          <= '0;
                bus.cap_y          <= '0;
            end
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            bus.cap_x[vec] <= bus.x;
            bus.cap_y[vec] <= bus.y;
            hold_cnt       <= '0;
            if (mismatch) begin
                bus.err_count <= bus.err_count + 4'd1;
                if (bus.err_count == '0) begin
                    bus.first_fail_vec <= vec;
                    bus.first_fail_xy  <= {bus.x, bus.y};
                end
            end
            // the last sample is folded into pass on the same edge done rises
            if (vec == 3'd7) begin
                state    <= DONE;
                bus.busy <= 1'b0;
                bus.done <= 1'b1;
                bus.pass <= (bus.err_count == '0) && !mismatch;
            end else begin
                vec <= vec + 3'd1;
            end
        end
    end
endmodule

// File: doc/exhaustive_vector_checker.md
Name: exhaustive_vector_checker

Overview:
- Hardware self-test engine for a 3-input / 2-output combinational unit (inputs a,b,c; outputs x,y), such as the lab full-adder-style blocks.
- On start, drives all eight {a,b,c} vectors 000..111 in ascending order and samples x,y after a programmable settle time.
- Compares each sample against a parameterised truth table, accumulates a mismatch count, and records the first failure.
- Sits between a board-level start button or controller and the unit under test; it is the checker side that consumes the unit's responses.

Parameters:
- HOLD_CYCLES, 4, clock cycles each vector is held before sampling; legal range >= 1.
- EXP_X, 8'b1110_1000, expected x truth table; bit i is the expected x for {a,b,c} == i (default is full-adder carry).
- EXP_Y, 8'b1001_0110, expected y truth table, same indexing (default is full-adder sum).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begins a sweep; sampled at clk edge; honoured only in IDLE or DONE.
- a  out  1  vector bit 2 to unit under test.
- b  out  1  vector bit 1.
- c  out  1  vector bit 0.
- x  in  1  unit response.
- y  in  1  unit response.
- busy  out  1  high while a sweep is in progress.
- done  out  1  high from sweep completion until the next accepted start.
- pass  out  1  high in DONE when err_count == 0; otherwise 0.
- err_count  out  4  number of vectors with any mismatch, 0..8.
- first_fail_vec  out  3  index of the first mismatching vector.
- first_fail_xy  out  2  observed {x,y} at first_fail_vec.
- cap_x  out  8  captured x per vector; bit i corresponds to vector i.
- cap_y  out  8  captured y per vector; bit i corresponds to vector i.

Behaviour:
- Clocking and reset: one clock. Reset is asynchronous and active-low. rst_n low immediately forces:
  - state to IDLE;
  - a, b, c, busy, done, pass to 0;
  - err_count, first_fail_vec, first_fail_xy, cap_x, cap_y to 0;
  - the internal vector register and hold counter to 0.
- Reset mid-sweep aborts the sweep with no partial result retained.
- FSM states are IDLE, RUN, DONE.
- IDLE -> RUN when start = 1 at an edge (edge k). At edge k:
  - vec = 0, hold_cnt = 0, busy = 1, done = 0, pass = 0;
  - err_count, first_fail_*, cap_* are cleared.
- {a,b,c} is always the registered vec. Outputs are registered with no combinational path from start.
- RUN, per edge:
  - If hold_cnt < HOLD_CYCLES-1: hold_cnt increments.
  - If hold_cnt == HOLD_CYCLES-1 (sample edge), all of the following happen in the same edge:
    - capture x into cap_x[vec] and y into cap_y[vec];
    - mismatch = (x != EXP_X[vec]) | (y != EXP_Y[vec]);
    - on mismatch, err_count increments; if err_count was 0, first_fail_vec = vec and first_fail_xy = {x,y};
    - hold_cnt = 0;
    - if vec == 7: go to DONE, busy = 0, done = 1, pass = (final err_count == 0), with the current sample included; otherwise vec increments.
- Timing: sample edges fall at k + n*HOLD_CYCLES for n = 1..8. done rises at edge k + 8*HOLD_CYCLES. Each vector is held exactly HOLD_CYCLES cycles.
- start while in RUN is ignored, with no effect on the sweep.
- DONE:
  - Results and done hold steady.
  - {a,b,c} stays at 111.
  - start = 1 restarts exactly as from IDLE (done drops at the same edge).
- err_count saturation is impossible: the maximum is 8, which fits in 4 bits.

Test Plan:
1. Default params with a correct full-adder model on x,y; start pulsed 1 cycle -> busy for 32 cycles, done at edge 32 after start; pass = 1, err_count = 0, cap_x = 8'hE8, cap_y = 8'h96; {a,b,c} steps 000..111 every 4 cycles.
2. Model with x stuck at 0 -> err_count = 4, pass = 0, first_fail_vec = 3, first_fail_xy = 2'b00, cap_x = 8'h00, cap_y = 8'h96.
3. HOLD_CYCLES = 1 with a correct model -> {a,b,c} changes every cycle; done 8 cycles after start; pass = 1.
4. Assert rst_n low at cycle 10 of a sweep, for 2 cycles, then release -> all outputs 0 immediately while rst_n is low; state IDLE; no sweep resumes until a new start.
5. Pulse start again at cycle 5 of a running sweep -> ignored; done still at edge 32 relative to the original start.
6. From DONE after a failing run, restart with a correct model -> done drops on the start edge; err_count and first_fail_* cleared; final pass = 1.
